// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with configurable data width,
// optional parity and one or two stop bits. The received word is held in
// a valid/ready output register with parity, framing, break and overrun
// flags. The FSM is written as state register / next-state / outputs.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t state, state_next;

    logic                 rx_meta, rxs;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 pend_par, pend_frame, pend_zero;

    // Control strobes produced by the output process
    logic tick_hit, cnt_clr, start_ok, shift_en, par_en, stop_en;
    logic frame_end, fe_fin, brk_fin;

    // Two-flop synchroniser for the asynchronous serial line (idle high)
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rxs) state_next = START;
            START:     if (tick_hit) state_next = rxs ? IDLE : DATA;
            DATA:      if (shift_en && bit_cnt == DATA_LAST)
                           state_next = HAS_PAR ? PARITY : STOP;
            PARITY:    if (par_en) state_next = STOP;
            STOP:      if (frame_end) state_next = fe_fin ? WAIT_IDLE : IDLE;
            WAIT_IDLE: if (rxs) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output process: sample strobes and end-of-frame flag values
    always_comb begin
        tick_hit  = 1'b0;
        cnt_clr   = 1'b0;
        start_ok  = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_en   = 1'b0;
        frame_end = 1'b0;
        // Stop-bit sample is the current rxs; a low stop bit is a frame error
        fe_fin    = pend_frame || !rxs;
        brk_fin   = pend_zero && !rxs;
        case (state)
            IDLE:   cnt_clr = !rxs;
            START:  begin
                tick_hit = b_tick && (tick_cnt == TICK_MID);
                cnt_clr  = tick_hit;
                start_ok = tick_hit && !rxs;
            end
            DATA:   begin
                tick_hit = b_tick && (tick_cnt == TICK_LAST);
                cnt_clr  = tick_hit;
                shift_en = tick_hit;
            end
            PARITY: begin
                tick_hit = b_tick && (tick_cnt == TICK_LAST);
                cnt_clr  = tick_hit;
                par_en   = tick_hit;
            end
            STOP:   begin
                tick_hit  = b_tick && (tick_cnt == TICK_LAST);
                cnt_clr   = tick_hit;
                stop_en   = tick_hit;
                frame_end = tick_hit && (bit_cnt == STOP_LAST);
            end
            default: ;
        endcase
    end

    // Oversample tick counter; runs only while a frame is in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (cnt_clr) begin
            tick_cnt <= '0;
        end else if (b_tick && state != IDLE && state != WAIT_IDLE) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Bit counter within the current state; restarts on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (state_next != state) begin
            bit_cnt <= '0;
        end else if (shift_en || stop_en) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Data shift register (LSB first) and pending per-frame error state
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            pend_par   <= 1'b0;
            pend_frame <= 1'b0;
            pend_zero  <= 1'b1;
        end else begin
            if (start_ok) begin
                pend_par   <= 1'b0;
                pend_frame <= 1'b0;
                pend_zero  <= 1'b1;
            end
            if (shift_en)
                shreg <= {rxs, shreg[DATA_BITS-1:1]};
            // Mismatch when XOR over data and parity bit differs from ODD
            if (par_en)
                pend_par <= (^shreg) ^ rxs ^ ODD;
            if (stop_en && !rxs)
                pend_frame <= 1'b1;
            if ((shift_en || par_en || stop_en) && rxs)
                pend_zero <= 1'b0;
        end
    end

    // Output holding register: a completed frame always overwrites
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            rx_valid   <= 1'b0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_done <= frame_end;
            if (frame_end) begin
                dout       <= shreg;
                rx_valid   <= 1'b1;
                parity_err <= pend_par;
                frame_err  <= fe_fin;
                break_det  <= brk_fin;
                overrun    <= rx_valid && !rx_ready;
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                break_det  <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances (8N1, 7E1, 8N2) share
// clk/reset/b_tick and each has its own rx line and rx_ready.
module tb_uart_rx_param;

    localparam int BITCLK = 64;   // 16 ticks per bit, one tick every 4 clk

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       b_tick = 1'b0;
    logic [2:0] rx = 3'b111;
    logic [2:0] rdy = 3'b111;
    logic [7:0] dout0, dout2;
    logic [6:0] dout1;
    logic [2:0] vld, done, pe, fe, brk, ovr;

    int errs = 0;
    int checks = 0;
    int ndone[3];
    logic [7:0] cap_d[3];
    logic cap_pe[3], cap_fe[3], cap_brk[3], cap_ovr[3];
    int base;

    always #5 clk = ~clk;

    uart_rx_param u0 (
        .clk(clk), .reset(reset), .b_tick(b_tick), .rx(rx[0]), .dout(dout0),
        .rx_valid(vld[0]), .rx_ready(rdy[0]), .rx_done(done[0]),
        .parity_err(pe[0]), .frame_err(fe[0]), .break_det(brk[0]), .overrun(ovr[0])
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .reset(reset), .b_tick(b_tick), .rx(rx[1]), .dout(dout1),
        .rx_valid(vld[1]), .rx_ready(rdy[1]), .rx_done(done[1]),
        .parity_err(pe[1]), .frame_err(fe[1]), .break_det(brk[1]), .overrun(ovr[1])
    );

    uart_rx_param #(.STOP_BITS(2)) u2 (
        .clk(clk), .reset(reset), .b_tick(b_tick), .rx(rx[2]), .dout(dout2),
        .rx_valid(vld[2]), .rx_ready(rdy[2]), .rx_done(done[2]),
        .parity_err(pe[2]), .frame_err(fe[2]), .break_det(brk[2]), .overrun(ovr[2])
    );

    // b_tick: one clk in four
    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge clk);
            b_tick = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    end

    // Capture outputs at each rx_done pulse
    always @(negedge clk) begin
        if (done[0]) cap_d[0] = dout0;
        if (done[1]) cap_d[1] = {1'b0, dout1};
        if (done[2]) cap_d[2] = dout2;
        for (int i = 0; i < 3; i++) begin
            if (done[i]) begin
                ndone[i]   = ndone[i] + 1;
                cap_pe[i]  = pe[i];
                cap_fe[i]  = fe[i];
                cap_brk[i] = brk[i];
                cap_ovr[i] = ovr[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive n bits LSB first, one bit period each, then return line high
    task automatic send(input int ch, input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx[ch] = bits[i];
            repeat (BITCLK) @(negedge clk);
        end
        rx[ch] = 1'b1;
    endtask

    task automatic idle(input int nb);
        repeat (nb * BITCLK) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) ndone[i] = 0;
        repeat (4) @(negedge clk);
        chk("rst_valid", vld, 3'b000);
        chk("rst_done", done, 3'b000);
        chk("rst_dout0", dout0, 8'h00);
        chk("rst_flags", {pe, fe, brk, ovr}, 12'h000);
        reset = 1'b0;
        idle(1);

        // 8N1 0xA5
        send(0, {1'b1, 8'hA5, 1'b0}, 10);
        idle(1);
        chk("a5_ndone", ndone[0], 1);
        chk("a5_dout", cap_d[0], 8'hA5);
        chk("a5_flags", {cap_pe[0], cap_fe[0], cap_brk[0], cap_ovr[0]}, 4'b0000);
        chk("a5_accepted", vld[0], 1'b0);

        // 7E1: 0x55 has four ones, so even parity bit is 0
        send(1, {1'b1, 1'b0, 7'h55, 1'b0}, 10);
        idle(1);
        chk("par_ok_ndone", ndone[1], 1);
        chk("par_ok_pe", cap_pe[1], 1'b0);
        send(1, {1'b1, 1'b1, 7'h55, 1'b0}, 10);
        idle(1);
        chk("par_bad_ndone", ndone[1], 2);
        chk("par_bad_pe", cap_pe[1], 1'b1);
        chk("par_bad_dout", cap_d[1], 8'h55);
        chk("par_bad_fe", cap_fe[1], 1'b0);

        // 8N2: second stop bit low, then the line stays low for 12 more bits
        send(2, {12'h000, 1'b0, 1'b1, 8'h3C, 1'b0}, 23);
        chk("stop2_ndone", ndone[2], 1);
        chk("stop2_fe", cap_fe[2], 1'b1);
        chk("stop2_brk", cap_brk[2], 1'b0);
        idle(2);
        send(2, {1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        idle(1);
        chk("stop2_clean_ndone", ndone[2], 2);
        chk("stop2_clean_dout", cap_d[2], 8'h3C);
        chk("stop2_clean_fe", cap_fe[2], 1'b0);

        // Break: 20 bit periods low on 8N1
        base = ndone[0];
        rx[0] = 1'b0;
        repeat (20 * BITCLK) @(negedge clk);
        rx[0] = 1'b1;
        idle(2);
        chk("brk_ndone", ndone[0], base + 1);
        chk("brk_dout", cap_d[0], 8'h00);
        chk("brk_flags", {cap_brk[0], cap_fe[0]}, 2'b11);

        // Overrun with rx_ready low
        base = ndone[0];
        rdy[0] = 1'b0;
        send(0, {1'b1, 8'h11, 1'b0}, 10);
        idle(1);
        chk("ovr_first_valid", vld[0], 1'b1);
        chk("ovr_first_ovr", cap_ovr[0], 1'b0);
        send(0, {1'b1, 8'h22, 1'b0}, 10);
        idle(1);
        chk("ovr_ndone", ndone[0], base + 2);
        chk("ovr_dout", cap_d[0], 8'h22);
        chk("ovr_flag", cap_ovr[0], 1'b1);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        @(negedge clk);
        chk("ovr_acc_valid", vld[0], 1'b0);
        chk("ovr_acc_ovr", ovr[0], 1'b0);
        chk("ovr_acc_dout", dout0, 8'h22);
        rdy[0] = 1'b1;

        // Glitch of 4 clk: rejected at the mid-start check
        base = ndone[0];
        rx[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx[0] = 1'b1;
        idle(12);
        chk("glitch_ndone", ndone[0], base);

        // Reset in the middle of data bit 3
        rx[0] = 1'b0;
        repeat (4 * BITCLK + BITCLK / 2) @(negedge clk);
        reset = 1'b1;
        rx[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_valid", vld[0], 1'b0);
        chk("rst_mid_dout", dout0, 8'h00);
        chk("rst_mid_flags", {pe[0], fe[0], brk[0], ovr[0], done[0]}, 5'b00000);
        reset = 1'b0;
        idle(12);
        chk("rst_mid_ndone", ndone[0], base);
        send(0, {1'b1, 8'hF0, 1'b0}, 10);
        idle(1);
        chk("f0_ndone", ndone[0], base + 1);
        chk("f0_dout", cap_d[0], 8'hF0);
        chk("f0_flags", {cap_pe[0], cap_fe[0], cap_brk[0], cap_ovr[0]}, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8N1 UART receiver. Adds configurable data width, optional parity, and 1 or 2 stop bits. Adds parity, framing and break error reporting, plus a valid/ready output holding register with overrun detection. Sits between the BAUDGEN oversampling tick and the AHB UART receive path.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, b_tick pulses per bit period (even, 8..32)
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only when PARITY_EN=1)
STOP_BITS, 1, number of stop bits checked (1 or 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
b_tick  input  1  one-clk oversample strobe from BAUDGEN
rx  input  1  serial line, idle high, asynchronous
dout  output  DATA_BITS  received data word
rx_valid  output  1  dout and flags are valid; held until accepted
rx_ready  input  1  consumer accepts dout when rx_valid && rx_ready
rx_done  output  1  one-clk pulse when a frame completes
parity_err  output  1  parity mismatch on the held word
frame_err  output  1  any stop bit sampled low on the held word
break_det  output  1  data, parity and stop bits all sampled 0
overrun  output  1  held word overwrote an unaccepted word

Behaviour:
- Clock and reset: one clock clk. reset is synchronous and active-high.
- Reset state: all outputs 0. State = IDLE. Tick and bit counters = 0. Both rx synchroniser flops = 1.
- rx passes through a 2-flop synchroniser; rxs is the synchronised signal. All sampling uses rxs. Counters advance only on clk edges where b_tick=1.
- IDLE: on rxs=0, go to START and clear the tick counter.
- START: after OVERSAMPLE/2 ticks (mid-bit), sample rxs.
  - rxs=1: false start; return to IDLE with no flags.
  - rxs=0: go to DATA, clear the tick counter.
- DATA: sample every OVERSAMPLE ticks. Shift LSB first. After DATA_BITS samples, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: sample one bit after OVERSAMPLE ticks.
  - Even parity requires XOR(data, pbit)=0. Odd parity requires it to be 1.
  - Mismatch sets the pending parity flag.
- STOP: sample STOP_BITS bits, each after OVERSAMPLE ticks. Any 0 sets the pending frame flag.
- Break: pending break is set if the data bits, parity bit (if present) and every stop bit were all 0. A break also sets frame flag = 1.
- Frame completion: on the clk edge of the last stop sample:
  - dout, parity_err, frame_err, break_det are loaded. rx_valid=1. rx_done=1 for exactly that cycle.
  - overrun = 1 if rx_valid was 1 and rx_ready was 0 in that cycle; else 0.
  - New data always overwrites. Ready logic is never blocked.
- Completion and rx_ready=1 in the same cycle: the old word is consumed, the new word is loaded, rx_valid stays 1, overrun=0.
- Acceptance without a completion: rx_valid && rx_ready clears rx_valid, parity_err, frame_err, break_det and overrun on the next edge. dout retains its value.
- Frame-error recovery: after a frame with frame_err, go to WAIT_IDLE and stay until rxs=1, then go to IDLE. A held-low line must not retrigger frames. Without frame_err, go directly to IDLE.
- Reset asserted mid-frame: abort the frame on the next edge. No rx_done. All outputs 0.
- b_tick is ignored in IDLE and WAIT_IDLE. rx glitches shorter than half a bit are rejected by the START check.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- Latency: rx_done asserts 2 clk after the mid-point of the last stop bit, due to synchroniser delay.

Test Plan:
- 8N1 defaults, 50 MHz clk, 19200 baud, rx_ready=1. Send 0xA5 -> one rx_done pulse, dout=0xA5, all error flags 0.
- DATA_BITS=7, PARITY_EN=1, PARITY_ODD=0. Send 0x55 with parity bit 0 -> parity_err=0. Send 0x55 with parity bit 1 -> parity_err=1, dout=0x55.
- STOP_BITS=2. Send 0x3C with the second stop bit low -> frame_err=1. No new frame until rx returns high; then 0x3C sends cleanly with frame_err=0.
- Hold rx low for 20 bit periods -> exactly one rx_done, dout=0x00, break_det=1, frame_err=1. No further rx_done until rx high plus a new start bit.
- rx_ready=0. Send 0x11 then 0x22 -> second rx_done gives dout=0x22, overrun=1. Pulse rx_ready -> rx_valid=0, overrun=0.
- rx low for 4 clk (glitch) -> no rx_done. Separately, assert reset during bit 3 of a frame -> outputs 0, no rx_done. The next full frame 0xF0 is received correctly.
